cla_wide_add_seq: RTL and testbench

Multi-cycle sequencer that performs wide add/subtract by time-sharing one WORD_W-bit hierarchical carry-lookahead adder across NUM_WORDS word slices, least-significant slice first. It latches full-width operands on a valid/ready handshake, registers the inter-slice carry, and presents the full-width result with a valid/ready handshake. It sits between the datapath issue logic and the CLA adder, and trades adder area for NUM_WORDS cycles of latency.

---
 rtl/cla_seq_pkg.sv | 19 +
 rtl/cla_adder_word.sv | 91 +++++++++
 rtl/cla_wide_add_seq.sv | 152 +++++++++++++++
 tb/tb_cla_wide_add_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the wide add/subtract sequencer: FSM encoding,
// default geometry and a slice-index width helper.
package cla_seq_pkg;

  localparam int unsigned WORD_W_DEF    = 32;
  localparam int unsigned NUM_WORDS_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // A single-slice build still needs a one-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_adder_word.sv
// WORD_W-bit hierarchical carry-lookahead adder built from 4-bit lookahead
// cells: bit cells, then block cells over groups of four, then block carries.
module cla_lcu4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c,
  output logic       pg,
  output logic       gg
);
  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    pg   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

module cla_adder_word #(
  parameter int unsigned WORD_W = 32
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout,
  output logic              c_msb
);
  localparam int unsigned NG = WORD_W / 4;
  localparam int unsigned NB = (NG + 3) / 4;

  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] bc;
  logic [NG-1:0]     grp_p;
  logic [NG-1:0]     grp_g;
  logic [NB*4-1:0]   grp_p_pad;
  logic [NB*4-1:0]   grp_g_pad;
  logic [NB*4-1:0]   grp_c;
  logic [NB-1:0]     blk_p;
  logic [NB-1:0]     blk_g;
  logic [NB:0]       blk_c;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar i = 0; i < NG; i++) begin : g_bit
    cla_lcu4 u_cell (
      .p   (p[4*i +: 4]),
      .g   (g[4*i +: 4]),
      .cin (grp_c[i]),
      .c   (bc[4*i +: 4]),
      .pg  (grp_p[i]),
      .gg  (grp_g[i])
    );
  end

  // Unused group slots propagate (p=1, g=0) so the block terms stay exact.
  if (NB * 4 > NG) begin : g_pad
    assign grp_p_pad = {{(NB*4-NG){1'b1}}, grp_p};
    assign grp_g_pad = {{(NB*4-NG){1'b0}}, grp_g};
  end else begin : g_nopad
    assign grp_p_pad = grp_p;
    assign grp_g_pad = grp_g;
  end

  for (genvar j = 0; j < NB; j++) begin : g_blk
    cla_lcu4 u_cell (
      .p   (grp_p_pad[4*j +: 4]),
      .g   (grp_g_pad[4*j +: 4]),
      .cin (blk_c[j]),
      .c   (grp_c[4*j +: 4]),
      .pg  (blk_p[j]),
      .gg  (blk_g[j])
    );
  end

  always_comb begin
    blk_c[0] = cin;
    for (int k = 0; k < NB; k++) begin
      blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
    end
  end

  assign sum   = p ^ bc;
  assign cout  = blk_c[NB];
  assign c_msb = bc[WORD_W-1];

endmodule

// File: rtl/cla_wide_add_seq.sv
// Wide add/subtract sequencer sharing one cla_adder_word across NUM_WORDS
// slices, LSB first. Define CLA_SEQ_OVF_EN to add the registered ovf output.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE, and sum/cout
// (and ovf) are stable for as long as out_valid is high.
module cla_wide_add_seq
  import cla_seq_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
  parameter int unsigned W         = WORD_W * NUM_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic [1:0]   dbg_state
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int unsigned        IDX_W    = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [W-1:0]      op_a_q, op_a_d;
  logic [W-1:0]      op_b_q, op_b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [WORD_W-1:0] slice_a;
  logic [WORD_W-1:0] slice_b;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;
  logic              add_c_msb;

  assign slice_a = op_a_q[int'(idx_q)*WORD_W +: WORD_W];
  assign slice_b = op_b_q[int'(idx_q)*WORD_W +: WORD_W];

  cla_adder_word #(.WORD_W(WORD_W)) u_adder (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_q),
    .sum   (add_sum),
    .cout  (add_cout),
    .c_msb (add_c_msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)            state_d = RUN;
      RUN:     if (idx_q == LAST_IDX)   state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    dbg_state = state_q;
  end

  // Subtract is A + ~B + 1: invert B once at accept and seed the carry with sub.
  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub;
          idx_d   = '0;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*WORD_W +: WORD_W] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          cout_d = add_cout;
          idx_d  = '0;
        end else begin
          idx_d  = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && idx_q == LAST_IDX) ovf_d = add_c_msb ^ add_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = add_c_msb;
`endif

endmodule

// File: tb/tb_cla_wide_add_seq.sv
// Self-checking bench for cla_wide_add_seq: directed corner cases plus random
// add/subtract traffic scored against a plain-arithmetic reference model.
module tb_cla_wide_add_seq;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned W         = WORD_W * NUM_WORDS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;
`ifdef CLA_SEQ_OVF_EN
  logic         ovf;
  logic         exp_ovf_q[$];
`endif

  logic [W:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  cla_wide_add_seq #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
`ifdef CLA_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model
  function automatic logic [W:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s);
    logic [W-1:0] r;
    r = s ? (x - y) : (x + y);
    if (s) return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int i = 0; i < NUM_WORDS; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    int n;
    n = 0;
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept ready", W'(in_ready), 1);
    @(posedge clk); #1;
    exp_q.push_back(ref_res(ta, tb, ts));
`ifdef CLA_SEQ_OVF_EN
    exp_ovf_q.push_back(ref_ovf(ta, tb, ts));
`endif
    // Keep presenting junk: it must be ignored outside IDLE.
    a = rnd_w(); b = rnd_w(); sub = 1'($urandom_range(0, 1));
    chk("busy after accept", W'(in_ready), 0);
  endtask

  task automatic collect(input string tag, input int hold);
    int n;
    logic [W:0] e;
`ifdef CLA_SEQ_OVF_EN
    logic eo;
`endif
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, W'(n), W'(NUM_WORDS));
    e = exp_q.pop_front();
`ifdef CLA_SEQ_OVF_EN
    eo = exp_ovf_q.pop_front();
`endif
    chk({tag, " sum"},  {1'b0, sum}, {1'b0, e[W-1:0]});
    chk({tag, " cout"}, W'(cout), W'(e[W]));
`ifdef CLA_SEQ_OVF_EN
    chk({tag, " ovf"},  W'(ovf), W'(eo));
`endif
    for (int i = 0; i < hold; i++) begin
      a = rnd_w(); b = rnd_w(); in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, " hold sum"},   {1'b0, sum}, {1'b0, e[W-1:0]});
      chk({tag, " hold cout"},  W'(cout), W'(e[W]));
      chk({tag, " hold ready"}, W'({in_ready, out_valid}), W'(2'b01));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, " back to idle"}, W'({in_ready, out_valid, dbg_state}), W'(4'b1000));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] msb;
    ones = '1;
    msb  = '0;
    msb[W-1] = 1'b1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready",  W'(in_ready), 1);
    chk("reset valid",  W'(out_valid), 0);
    chk("reset sum",    {1'b0, sum}, '0);
    chk("reset cout",   W'(cout), 0);
    chk("reset state",  W'(dbg_state), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(ones, {{(W-1){1'b0}}, 1'b1}, 1'b0);
    collect("add wrap", 0);
    send('0, {{(W-1){1'b0}}, 1'b1}, 1'b1);
    collect("sub borrow", 0);
    send(W'(5), W'(3), 1'b1);
    collect("sub 5-3", 0);
    chk("5-3 literal", {cout, sum}, {1'b1, W'(2)});

    // Reset while idle clears the held result.
    rst_n = 1'b0; #1;
    chk("idle reset sum",  {1'b0, sum}, '0);
    chk("idle reset outs", W'({in_ready, out_valid, cout}), W'(3'b100));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    send(rnd_w(), rnd_w(), 1'b0);
    collect("backpressure", 10);

    send(rnd_w(), rnd_w(), 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("abort state",  W'({in_ready, out_valid, dbg_state}), W'(4'b1000));
    chk("abort sum",    {1'b0, sum}, '0);
    chk("abort cout",   W'(cout), 0);
    void'(exp_q.pop_front());
`ifdef CLA_SEQ_OVF_EN
    void'(exp_ovf_q.pop_front());
`endif
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send(W'(7), W'(9), 1'b0);
    collect("after abort", 0);

`ifdef CLA_SEQ_OVF_EN
    send(msb - 1'b1, {{(W-1){1'b0}}, 1'b1}, 1'b0);
    collect("ovf add", 0);
    chk("ovf add flag", W'(ovf), 1);
    send(msb, {{(W-1){1'b0}}, 1'b1}, 1'b1);
    collect("ovf sub", 0);
    chk("ovf sub flag", W'(ovf), 1);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = rnd_w();
      y = (i % 4 == 0) ? x : rnd_w();
      if (i % 6 == 1) y = ~x;
      send(x, y, 1'($urandom_range(0, 1)));
      collect("random", $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
